// File: rtl/prog_clock_divider.sv
// Synchronous clock-enable generator: a binary divider chain taken from one up-counter,
// plus a runtime-programmable down-counter that produces a one-cycle tick and a 50%-duty tick_clk.
module prog_clock_divider #(
    parameter int WIDTH       = 16,
    parameter int STAGES      = 4,
    parameter int DEFAULT_DIV = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              div_load,
    input  logic [WIDTH-1:0]  div_value,
    input  logic              sync,
    output logic [STAGES-1:0] div_out,
    output logic              tick,
    output logic              tick_clk,
    output logic [WIDTH-1:0]  count
);

    localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0]  div_reg;
    logic [STAGES-1:0] bin;

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_reg  <= RESET_DIV;
            count    <= RESET_DIV;
            bin      <= '0;
            tick     <= 1'b0;
            tick_clk <= 1'b0;
        end else begin
            if (div_load) begin
                div_reg <= div_value;
            end
            // A phase restart overrides any terminal count on the same edge; a
            // simultaneous load restarts straight from the incoming value.
            if (sync) begin
                count <= div_load ? div_value : div_reg;
                bin   <= '0;
                tick  <= 1'b0;
            end else if (en) begin
                bin <= bin + STAGES'(1);
                if (count == '0) begin
                    count    <= div_reg;
                    tick     <= 1'b1;
                    tick_clk <= ~tick_clk;
                end else begin
                    count <= count - WIDTH'(1);
                    tick  <= 1'b0;
                end
            end else begin
                tick <= 1'b0;
            end
        end
    end

    assign div_out = bin;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider (default parameters): vector table for the
// reset/tick/freeze schedule, then hand-written sequences for load, sync and div_reg=0.
module tb_prog_clock_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        div_load;
    logic [15:0] div_value;
    logic        sync;
    logic [3:0]  div_out;
    logic        tick;
    logic        tick_clk;
    logic [15:0] count;

    int checks = 0;
    int errors = 0;

    prog_clock_divider #(.WIDTH(16), .STAGES(4), .DEFAULT_DIV(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .div_load  (div_load),
        .div_value (div_value),
        .sync      (sync),
        .div_out   (div_out),
        .tick      (tick),
        .tick_clk  (tick_clk),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic        ld;
        logic [15:0] val;
        logic        sy;
        logic [15:0] c;
        logic        t;
        logic        tc;
        logic [3:0]  d;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic e, logic ld, logic [15:0] val, logic sy,
                                logic [15:0] c, logic t, logic tc, logic [3:0] d);
        vec_t v;
        v.rst = rst; v.en = e; v.ld = ld; v.val = val; v.sy = sy;
        v.c = c; v.t = t; v.tc = tc; v.d = d;
        return v;
    endfunction

    task automatic step(input logic rst, input logic e, input logic ld,
                        input logic [15:0] val, input logic sy);
        reset = rst; en = e; div_load = ld; div_value = val; sync = sy;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] c, input logic t,
                         input logic tc, input logic [3:0] d);
        checks++;
        if (count !== c) begin
            errors++;
            $display("FAIL %s count: got %0d want %0d", name, count, c);
        end
        checks++;
        if (tick !== t) begin
            errors++;
            $display("FAIL %s tick: got %b want %b", name, tick, t);
        end
        checks++;
        if (tick_clk !== tc) begin
            errors++;
            $display("FAIL %s tick_clk: got %b want %b", name, tick_clk, tc);
        end
        checks++;
        if (div_out !== d) begin
            errors++;
            $display("FAIL %s div_out: got %0d want %0d", name, div_out, d);
        end
    endtask

    initial begin
        logic tc_exp;
        reset = 1'b0; en = 1'b0; div_load = 1'b0; div_value = '0; sync = 1'b0;

        // reset for two edges, then free-running with en=1
        tbl.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 2, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 2));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(1, 1, 0, 0, 0, 3, 1, 1, 4));
        tbl.push_back(mk(1, 1, 0, 0, 0, 2, 0, 1, 5));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 1, 6));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 7));
        tbl.push_back(mk(1, 1, 0, 0, 0, 3, 1, 0, 8));
        tbl.push_back(mk(1, 1, 0, 0, 0, 2, 0, 0, 9));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 10));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 11));
        tbl.push_back(mk(1, 1, 0, 0, 0, 3, 1, 1, 12));
        tbl.push_back(mk(1, 1, 0, 0, 0, 2, 0, 1, 13));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 1, 14));
        // freeze with count=1
        for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 14));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 15));
        tbl.push_back(mk(1, 1, 0, 0, 0, 3, 1, 0, 0));

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].ld, tbl[i].val, tbl[i].sy);
            check($sformatf("vec%0d", i), tbl[i].c, tbl[i].t, tbl[i].tc, tbl[i].d);
        end

        // load 9 while count=2: old schedule finishes, then a 10-cycle period
        step(1, 1, 0, 0, 0);  check("pre_load", 2, 0, 0, 1);
        step(1, 1, 1, 9, 0);  check("load_edge", 1, 0, 0, 2);
        step(1, 1, 0, 0, 0);  check("old_sched", 0, 0, 0, 3);
        step(1, 1, 0, 0, 0);  check("old_tick", 9, 1, 1, 4);
        for (int k = 0; k < 9; k++) begin
            step(1, 1, 0, 0, 0);
            check($sformatf("new_cnt%0d", k), 16'(8 - k), 0, 1, 4'(5 + k));
        end
        step(1, 1, 0, 0, 0);  check("new_tick", 9, 1, 0, 14);

        // sync with simultaneous load restarts from the new value
        step(1, 1, 1, 5, 1);  check("sync_load", 5, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(1, 1, 0, 0, 0);
            check($sformatf("after_sl%0d", k), 16'(4 - k), 0, 0, 4'(1 + k));
        end
        // count is 0 here: sync wins, no tick
        step(1, 1, 0, 0, 1);  check("sync_at_zero", 5, 0, 0, 0);
        step(1, 0, 0, 0, 1);  check("sync_no_en", 5, 0, 0, 0);

        // reset mid-count discards the loaded divider
        step(1, 1, 1, 9, 0);  check("load9", 4, 0, 0, 1);
        step(0, 1, 0, 0, 0);  check("mid_reset", 3, 0, 0, 0);
        step(1, 1, 0, 0, 0);  check("post_rst1", 2, 0, 0, 1);
        step(1, 1, 0, 0, 0);  check("post_rst2", 1, 0, 0, 2);
        step(1, 1, 0, 0, 0);  check("post_rst3", 0, 0, 0, 3);
        step(1, 1, 0, 0, 0);  check("post_rst4", 3, 1, 1, 4);

        // div_reg=0: tick every cycle, tick_clk alternates
        step(1, 1, 1, 0, 0);  check("load0", 2, 0, 1, 5);
        step(1, 1, 0, 0, 1);  check("sync0", 0, 0, 1, 0);
        tc_exp = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tc_exp = ~tc_exp;
            step(1, 1, 0, 0, 0);
            check($sformatf("div0_%0d", k), 0, 1, tc_exp, 4'(1 + k));
        end

        // 32 enabled edges: div_out walks 0..15 twice, msb 8 high / 8 low
        step(0, 0, 0, 0, 0);  check("reset2", 3, 0, 0, 0);
        for (int k = 1; k <= 32; k++) begin
            step(1, 1, 0, 0, 0);
            checks++;
            if (div_out !== 4'(k % 16)) begin
                errors++;
                $display("FAIL bin_walk%0d div_out: got %0d want %0d", k, div_out, k % 16);
            end
            checks++;
            if (div_out[3] !== ((k % 16) >= 8)) begin
                errors++;
                $display("FAIL msb%0d div_out[3]: got %b want %b", k, div_out[3], (k % 16) >= 8);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_clock_divider.md
# prog_clock_divider

Parametrised synchronous successor to the fixed ripple divider. It produces STAGES binary-divided outputs from a single counter with no ripple or derived clocks. It also provides a runtime-programmable tick generator, with a one-cycle `tick` enable and a 50%-duty `tick_clk`, for frame/pixel/game-logic pacing. All outputs are registered in the `clk` domain and are intended as clock enables downstream, not as clocks.

## Interface
Parameters:
- `WIDTH`, 16: width of the programmable divider (`div_value`, `count`).
- `STAGES`, 4: number of binary divided outputs, 1..16.
- `DEFAULT_DIV`, 3: divider reload value after reset; must fit in WIDTH bits.

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `en`  in  1  count enable; 0 freezes all counters.
- `div_load`  in  1  capture `div_value` into the divider register `div_reg`.
- `div_value`  in  WIDTH  new divider value; tick period = `div_value`+1 cycles.
- `sync`  in  1  phase restart: `count`<=`div_reg`, binary counter<=0.
- `div_out`  out  STAGES  `div_out[k]` toggles every 2^k enabled cycles (clk/2^(k+1)).
- `tick`  out  1  one-cycle pulse at each terminal count.
- `tick_clk`  out  1  toggles on every tick; period 2*(`div_reg`+1).
- `count`  out  WIDTH  current down-counter value.

## Operation
- Binary section: STAGES-bit up-counter `bin`, `div_out` = `bin`. Increments when `en`=1, wraps from all-ones to 0.
- Programmable section: down-counter `count`.
  - Edge with `en`=1 and `count`!=0: `count`<=`count`-1, `tick`<=0.
  - Edge with `en`=1 and `count`==0: `count`<=`div_reg`, `tick`<=1, `tick_clk`<=~`tick_clk`.
- `en`=0: `bin`, `count` and `tick_clk` hold; `tick`<=0.
- `div_load`=1: `div_reg`<=`div_value`. Takes effect at the next reload; the current countdown is not disturbed.
- `sync`=1, regardless of `en`: `count`<=`div_reg`, `bin`<=0, `tick`<=0. `tick_clk` holds.
- `sync` and `div_load` asserted together: `count`<=`div_value`, the new value, and `div_reg`<=`div_value`.
- `sync` coinciding with `count`==0 and `en`=1: `sync` wins and no tick is produced.
- `div_reg`=0: `count` stays 0, `tick` is held at 1 every enabled cycle, and `tick_clk` toggles every cycle.
- `reset` has priority over all other inputs.

## Timing
- Reset values (edge with `reset`=0): `div_reg`=DEFAULT_DIV, `count`=DEFAULT_DIV, `bin`=0, `div_out`=0, `tick`=0, `tick_clk`=0.
- Reset mid-count discards all state, including any loaded `div_reg`.
- Latency: all outputs change only on rising edges; there are no combinational paths from input to output.
- Tick timing with DEFAULT_DIV=3, `en`=1 from reset release:
  - edge1 `count`=2, edge2 `count`=1, edge3 `count`=0.
  - edge4 `count`=3, `tick`=1.
  - The next tick is at edge8.
- `div_out[0]` is high after odd-numbered enabled edges. `div_out[STAGES-1]` period = 2^STAGES cycles.
- Load at edge n while `count`=c: the next tick follows the old schedule. The tick after that comes `div_value`+1 cycles later.

## Test plan
- Reset (`reset`=0 for 2 edges) -> all outputs 0, `count`=3. Release with `en`=1 -> `tick` at edges 4, 8, 12. `tick_clk` high after edge4, low after edge8.
- STAGES=4, `en`=1 for 32 edges -> `div_out` steps 0..15 twice. `div_out[3]` is high for 8 cycles, low for 8 cycles.
- `en`=0 for 5 cycles with `count`=1 -> `count`, `div_out` and `tick_clk` unchanged, `tick`=0. With `en` back to 1, the tick arrives 2 edges later.
- `div_value`=0 with `div_load`, then `sync` -> `tick` held at 1 every cycle, `tick_clk` alternates each cycle.
- With `count`=2, load `div_value`=9 -> tick after 3 edges, then the next tick 10 edges later. Repeat with `sync`+`div_load` together -> `count`=9 on the next edge.
- `sync` on the edge where `count`=0 -> no tick, `count`=`div_reg`, `bin`=0. Assert `reset`=0 mid-count with `div_reg`=9 -> `count`=3 after the edge.
